// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Package    : motor_pkg
// Description: Command codes shared with the car-control FSM and the motor
//              driver state encoding.
// Revision   : 1.0 - initial release
// ============================================================================
package motor_pkg;

    localparam logic [2:0] M1_STOP     = 3'd0;
    localparam logic [2:0] M1_SLOW     = 3'd1;
    localparam logic [2:0] M1_MED      = 3'd2;
    localparam logic [2:0] M1_HIGH     = 3'd3;
    localparam logic [2:0] M1_REV      = 3'd4;

    localparam logic [1:0] M2_STRAIGHT = 2'd0;
    localparam logic [1:0] M2_RIGHT    = 2'd1;
    localparam logic [1:0] M2_LEFT     = 2'd2;

    localparam logic [1:0] S_OFF       = 2'd0;
    localparam logic [1:0] S_FWD       = 2'd1;
    localparam logic [1:0] S_REV       = 2'd2;
    localparam logic [1:0] S_DRAIN     = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module     : pwm_channel
// Description: One wheel PWM output: period-aligned duty shadow compared
//              against the shared counter, with an immediate force-to-zero.
// Revision   : 1.0 - initial release
// ============================================================================
module pwm_channel #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [PWM_W-1:0] cnt,
    input  logic [PWM_W-1:0] duty,
    input  logic             load,
    input  logic             force0,
    output logic             pwm
);

    logic [PWM_W-1:0] r_shadow;

    always_ff @(posedge clk) begin
        if (clr || force0) begin
            r_shadow <= '0;
        end else if (load) begin
            r_shadow <= duty;
        end
    end

    assign pwm = (cnt < r_shadow);

endmodule
`default_nettype wire

// File: rtl/motor_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module     : motor_pwm_driver
// Description: Turns control-FSM commands into wheel PWM/direction with safe
//              reversal, plus brake and blinking indicator lamps.
//              Duty ramping is built only when MOTOR_RAMP_EN is defined.
// Revision   : 1.0 - initial release
// ============================================================================
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int PWM_W      = 8,
    parameter int DUTY_SLOW  = 64,
    parameter int DUTY_MED   = 128,
    parameter int DUTY_HIGH  = 255,
    parameter int RAMP_DIV   = 16,
    parameter int RAMP_STEP  = 8,
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       E,
    input  logic [2:0] M1,
    input  logic [1:0] M2,
    input  logic       TL,
    input  logic       RH,
    input  logic       LH,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic       dir_l,
    output logic       dir_r,
    output logic       brake_lamp,
    output logic       ind_l,
    output logic       ind_r,
    output logic       at_speed
);

    localparam logic [PWM_W-1:0] c_CNT_MAX    = '1;
    localparam int               c_BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_HALF - 1);

    logic [1:0]           r_state, w_state_nxt;
    logic                 r_dir;
    logic [PWM_W-1:0]     r_cur, w_cur_nxt;
    logic [PWM_W-1:0]     w_tgt, w_eff_tgt, w_duty_l, w_duty_r;
    logic [PWM_W-1:0]     r_cnt;
    logic                 w_tdir, w_load, w_force0, w_drain_done;
    logic [c_BLINK_W-1:0] r_blink;
    logic                 r_phase;

    always_comb begin
        w_tgt = '0;
        if (E) begin
            case (M1)
                M1_SLOW, M1_REV: w_tgt = PWM_W'(DUTY_SLOW);
                M1_MED:          w_tgt = PWM_W'(DUTY_MED);
                M1_HIGH:         w_tgt = PWM_W'(DUTY_HIGH);
                default:         w_tgt = '0;
            endcase
        end
    end

    assign w_tdir       = (M1 == M1_REV);
    // Wheels must coast to zero before the direction is allowed to change.
    assign w_eff_tgt    = (r_state == S_DRAIN || w_tdir != r_dir) ? '0 : w_tgt;
    assign w_drain_done = (r_state == S_DRAIN) && (r_cur == '0);
    assign w_force0     = !E || (r_state == S_OFF) || w_drain_done;
    assign w_load       = (r_cnt == c_CNT_MAX);

    always_comb begin
        w_state_nxt = r_state;
        if (!E) begin
            w_state_nxt = S_OFF;
        end else begin
            case (r_state)
                S_OFF:        w_state_nxt = w_tdir ? S_DRAIN : S_FWD;
                S_FWD, S_REV: if (w_tdir != r_dir) w_state_nxt = S_DRAIN;
                default:      if (r_cur == '0) w_state_nxt = w_tdir ? S_REV : S_FWD;
            endcase
        end
    end

`ifdef MOTOR_RAMP_EN
    localparam int               c_DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(RAMP_DIV - 1);
    localparam logic [PWM_W-1:0] c_STEP     = PWM_W'(RAMP_STEP);

    logic [c_DIV_W-1:0] r_div;
    logic               w_tick, w_ramp_down, r_brake_hold;

    assign w_tick = (r_div == c_DIV_LAST);

    always_ff @(posedge clk) begin
        if (clr || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_comb begin
        w_cur_nxt   = r_cur;
        w_ramp_down = 1'b0;
        if (w_tick) begin
            if (r_cur < w_eff_tgt) begin
                w_cur_nxt = (w_eff_tgt - r_cur > c_STEP) ? r_cur + c_STEP : w_eff_tgt;
            end else if (r_cur > w_eff_tgt) begin
                w_cur_nxt   = (r_cur - w_eff_tgt > c_STEP) ? r_cur - c_STEP : w_eff_tgt;
                w_ramp_down = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_brake_hold <= 1'b0;
        end else if (w_ramp_down && !w_force0) begin
            r_brake_hold <= 1'b1;
        end else if (w_load) begin
            r_brake_hold <= 1'b0;
        end
    end

    assign brake_lamp = TL | r_brake_hold;
`else
    logic w_unused_ramp;

    assign w_cur_nxt     = w_eff_tgt;
    assign w_unused_ramp = ^{RAMP_DIV, RAMP_STEP};
    assign brake_lamp    = TL;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_OFF;
            r_dir   <= 1'b0;
            r_cur   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= r_cnt + 1'b1;
            r_cur   <= w_force0 ? '0 : w_cur_nxt;
            if (w_drain_done && E) begin
                r_dir <= w_tdir;
            end
        end
    end

    always_comb begin
        w_duty_l = r_cur;
        w_duty_r = r_cur;
        if (M2 == M2_LEFT) begin
            w_duty_l = r_cur >> 1;
        end else if (M2 == M2_RIGHT) begin
            w_duty_r = r_cur >> 1;
        end
    end

    pwm_channel #(.PWM_W(PWM_W)) u_pwm_l (
        .clk    (clk),
        .clr    (clr),
        .cnt    (r_cnt),
        .duty   (w_duty_l),
        .load   (w_load),
        .force0 (w_force0),
        .pwm    (pwm_l)
    );

    pwm_channel #(.PWM_W(PWM_W)) u_pwm_r (
        .clk    (clk),
        .clr    (clr),
        .cnt    (r_cnt),
        .duty   (w_duty_r),
        .load   (w_load),
        .force0 (w_force0),
        .pwm    (pwm_r)
    );

    // Blink phase restarts at "off" whenever both requests drop.
    always_ff @(posedge clk) begin
        if (clr || !(RH || LH)) begin
            r_blink <= '0;
            r_phase <= 1'b0;
        end else if (r_blink == c_BLINK_LAST) begin
            r_blink <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_blink <= r_blink + 1'b1;
        end
    end

    assign dir_l    = r_dir;
    assign dir_r    = r_dir;
    assign ind_l    = LH & r_phase;
    assign ind_r    = RH & r_phase;
    assign at_speed = (r_cur == w_tgt) && (r_state != S_DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_motor_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module     : tb_motor_pwm_driver
// Description: Directed vector table plus hand-written sequences for
//              motor_pwm_driver; follows MOTOR_RAMP_EN like the design.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_motor_pwm_driver;
    import motor_pkg::*;

`ifdef MOTOR_RAMP_EN
    localparam int c_SETTLE = 600;
`else
    localparam int c_SETTLE = 6;
`endif

    logic       clk = 1'b0;
    logic       clr, E, TL, RH, LH;
    logic [2:0] M1;
    logic [1:0] M2;
    logic       pwm_l, pwm_r, dir_l, dir_r, brake_lamp, ind_l, ind_r, at_speed;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       e;
        logic [2:0] m1;
        logic [1:0] m2;
        logic       tl;
        logic [7:0] cur;
        logic       dir;
        logic       at;
        logic       br;
    } vec_t;

    vec_t vt [14];

    motor_pwm_driver #(
        .PWM_W(8), .DUTY_SLOW(64), .DUTY_MED(128), .DUTY_HIGH(255),
        .RAMP_DIV(4), .RAMP_STEP(8), .BLINK_HALF(10)
    ) dut (
        .clk(clk), .clr(clr), .E(E), .M1(M1), .M2(M2), .TL(TL), .RH(RH), .LH(LH),
        .pwm_l(pwm_l), .pwm_r(pwm_r), .dir_l(dir_l), .dir_r(dir_r),
        .brake_lamp(brake_lamp), .ind_l(ind_l), .ind_r(ind_r), .at_speed(at_speed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic settle();
        repeat (c_SETTLE) @(negedge clk);
    endtask

    task automatic sync_cnt(input logic [7:0] v);
        int k;
        k = 0;
        while (dut.r_cnt != v && k < 600) begin
            @(negedge clk);
            k++;
        end
        if (dut.r_cnt != v) begin
            n_vec++;
            n_err++;
            $display("FAIL sync_cnt: counter never reached %0d", v);
        end
    endtask

    task automatic measure(input string tag, input int exp_l, input int exp_r);
        int hl, hr;
        hl = 0;
        hr = 0;
        @(negedge clk);
        sync_cnt(8'd0);
        for (int i = 0; i < 256; i++) begin
            hl += int'(pwm_l);
            hr += int'(pwm_r);
            @(negedge clk);
        end
        chk({tag, " pwm_l high clks"}, hl, exp_l);
        chk({tag, " pwm_r high clks"}, hr, exp_r);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k, n_drain0, n_bad_dir;
        logic seen_brake, done;

        //            e     m1    m2    tl    cur      dir   at    br
        vt[0]  = '{1'b1, 3'd2, 2'd0, 1'b0, 8'd128, 1'b0, 1'b1, 1'b0};
        vt[1]  = '{1'b1, 3'd3, 2'd0, 1'b0, 8'd255, 1'b0, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 3'd1, 2'd1, 1'b0, 8'd64,  1'b0, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 3'd4, 2'd1, 1'b0, 8'd64,  1'b1, 1'b1, 1'b0};
        vt[4]  = '{1'b1, 3'd6, 2'd0, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0};
        vt[5]  = '{1'b1, 3'd5, 2'd0, 1'b1, 8'd0,   1'b0, 1'b1, 1'b1};
        vt[6]  = '{1'b1, 3'd4, 2'd0, 1'b0, 8'd64,  1'b1, 1'b1, 1'b0};
        vt[7]  = '{1'b1, 3'd0, 2'd0, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 3'd3, 2'd0, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 3'd3, 2'd3, 1'b0, 8'd255, 1'b0, 1'b1, 1'b0};
        vt[10] = '{1'b1, 3'd4, 2'd0, 1'b0, 8'd64,  1'b1, 1'b1, 1'b0};
        vt[11] = '{1'b0, 3'd4, 2'd0, 1'b0, 8'd0,   1'b1, 1'b1, 1'b0};
        vt[12] = '{1'b1, 3'd1, 2'd0, 1'b0, 8'd64,  1'b0, 1'b1, 1'b0};
        vt[13] = '{1'b1, 3'd7, 2'd0, 1'b1, 8'd0,   1'b0, 1'b1, 1'b1};

        clr = 1'b1; E = 1'b1; M1 = 3'd3; M2 = 2'd0; TL = 1'b0; RH = 1'b0; LH = 1'b0;

        // Reset held two clocks with a live high-speed command.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset outputs", {pwm_l, pwm_r, dir_l, dir_r, brake_lamp, ind_l, ind_r, at_speed}, 0);
            chk("reset state", dut.r_state, S_OFF);
        end

        clr = 1'b0;
        M1  = 3'd0;
        settle();
        chk("idle state fwd", dut.r_state, S_FWD);

        // Stop -> medium.
        M1 = 3'd2;
        chk("cur before change", dut.r_cur, 0);
`ifdef MOTOR_RAMP_EN
        k = 0;
        while (dut.r_cur == 0 && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("ramp first step", dut.r_cur, 8);
        for (int i = 2; i <= 16; i++) begin
            repeat (4) @(negedge clk);
            chk("ramp step", dut.r_cur, 8 * i);
        end
`else
        @(negedge clk);
        chk("cur one clk after change", dut.r_cur, 128);
`endif
        chk("at_speed med", at_speed, 1);
        measure("med straight", 128, 128);

        // Left turn with left indicator.
        M2 = 2'd2;
        LH = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            chk("ind_l blink", ind_l, (i / 10) % 2);
            chk("ind_r idle", ind_r, 0);
        end
        measure("med left", 64, 128);
        LH = 1'b0;
        @(negedge clk);
        chk("ind_l after release", ind_l, 0);
        RH = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk("ind_r restart", ind_r, (i / 10) % 2);
        end
        RH = 1'b0;
        M2 = 2'd0;

        // Medium forward -> reverse through DRAIN.
        M1 = 3'd4;
        k = 0; n_drain0 = 0; n_bad_dir = 0; seen_brake = 1'b0; done = 1'b0;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
            if (dut.r_state == S_DRAIN && dir_l) n_bad_dir++;
            if (dut.r_state == S_DRAIN && dut.r_cur == 0) n_drain0++;
            if (brake_lamp) seen_brake = 1'b1;
            if (dut.r_state == S_REV && at_speed) done = 1'b1;
        end
        chk("reversal completes", done, 1);
        chk("dir changed during drain", n_bad_dir, 0);
        chk("drain clks at zero", n_drain0, 1);
        chk("dir_l reverse", dir_l, 1);
        chk("dir_r reverse", dir_r, 1);
        chk("cur reverse", dut.r_cur, 64);
`ifdef MOTOR_RAMP_EN
        chk("brake during ramp-down", seen_brake, 1);
`else
        chk("brake with TL low", seen_brake, 0);
`endif

        for (int v = 0; v < 14; v++) begin
            E = vt[v].e; M1 = vt[v].m1; M2 = vt[v].m2; TL = vt[v].tl;
            settle();
            chk($sformatf("vec%0d cur", v), dut.r_cur, vt[v].cur);
            chk($sformatf("vec%0d dir", v), dir_l, vt[v].dir);
            chk($sformatf("vec%0d at_speed", v), at_speed, vt[v].at);
            chk($sformatf("vec%0d brake", v), brake_lamp, vt[v].br);
        end

        // Engine cut while PWM is high.
        E = 1'b1; M1 = 3'd2; M2 = 2'd0; TL = 1'b0;
        settle();
        sync_cnt(8'd10);
        chk("pwm_l high before cut", pwm_l, 1);
        E = 1'b0;
        @(negedge clk);
        chk("pwm_l after cut", pwm_l, 0);
        chk("pwm_r after cut", pwm_r, 0);
        chk("cur after cut", dut.r_cur, 0);
        chk("state after cut", dut.r_state, S_OFF);

        // Reset while running in reverse.
        E = 1'b1; M1 = 3'd4;
        settle();
        chk("dir before reset", dir_l, 1);
        clr = 1'b1;
        @(negedge clk);
        chk("mid reset cur", dut.r_cur, 0);
        chk("mid reset dir", dir_l, 0);
        chk("mid reset state", dut.r_state, S_OFF);
        chk("mid reset pwm", {pwm_l, pwm_r}, 0);
        clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
